// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32IM fetch stage: reset/bubble constants,
// fetch state encoding and a word-alignment helper.
package riscv_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;   // addi x0, x0, 0

   typedef enum logic [1:0] {
      S_RESET   = 2'b00,
      S_FETCH   = 2'b01,
      S_STALL   = 2'b10,
      S_DISCARD = 2'b11
   } fetch_state_e;

   // Force an address onto a 32-bit instruction word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_reg.sv
// Program counter: async reset to the reset vector, sequential +4 step
// (wraps modulo 2^32) and word-aligned target load.
module pc_reg
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc_en,
   input  logic        load_en,
   input  logic [31:0] load_value,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4
);

   logic [31:0] pc_d;
   logic [31:0] pc_q;

   // Next PC: a target load takes precedence over the sequential step.
   always_comb begin
      pc_d = pc_q;
      if (load_en) begin
         pc_d = word_align(load_value);
      end else if (inc_en) begin
         pc_d = pc_q + 32'd4;
      end else begin
         pc_d = pc_q;
      end
   end

   // PC state, returns to the reset vector asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= word_align(RESET_PC);
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc       = pc_q;
   assign pc_plus4 = pc_q + 32'd4;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, drives instruction memory (holding requests through
// busywait), and fills the IF/ID register. Redirect flushes and beats stall;
// a redirect during an outstanding request waits in S_DISCARD for the
// in-flight word, drops it, then fetches the pending target.
module instruction_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        CLK,
   input  logic        RESET,
   output logic [31:0] imem_addr,
   output logic        imem_read,
   input  logic [31:0] imem_readdata,
   input  logic        imem_busywait,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4,
   output logic [31:0] if_id_instr,
   output logic        if_id_valid
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_s, pc4_s, pc_target_s;
   logic         pc_inc_s, pc_load_s, imem_read_s;
   logic [31:0]  if_id_pc_q, if_id_pc_d, if_id_pc4_q, if_id_pc4_d;
   logic [31:0]  if_id_instr_q, if_id_instr_d;
   logic         if_id_valid_q, if_id_valid_d;
   logic [31:0]  hold_pc_q, hold_pc_d, hold_instr_q, hold_instr_d;
   logic         hold_valid_q, hold_valid_d;
   logic [31:0]  pending_target_q, pending_target_d;

   pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
      .clk        (CLK),
      .rst_n      (RESET),
      .inc_en     (pc_inc_s),
      .load_en    (pc_load_s),
      .load_value (pc_target_s),
      .pc         (pc_s),
      .pc_plus4   (pc4_s)
   );

   // Next-state, PC control and IF/ID / hold-buffer updates.
   always_comb begin
      state_d          = state_q;
      pc_inc_s         = 1'b0;
      pc_load_s        = 1'b0;
      pc_target_s      = redirect_target;
      if_id_pc_d       = if_id_pc_q;
      if_id_pc4_d      = if_id_pc4_q;
      if_id_instr_d    = if_id_instr_q;
      if_id_valid_d    = if_id_valid_q;
      hold_pc_d        = hold_pc_q;
      hold_instr_d     = hold_instr_q;
      hold_valid_d     = hold_valid_q;
      pending_target_d = pending_target_q;
      case (state_q)
         S_RESET: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            if (redirect) begin
               if_id_instr_d = NOP_INSTR;
               if_id_valid_d = 1'b0;
               hold_valid_d  = 1'b0;
               if (imem_busywait) begin
                  pending_target_d = word_align(redirect_target);
                  state_d          = S_DISCARD;
               end else begin
                  pc_load_s = 1'b1;   // word returned this cycle is wrong-path
                  state_d   = S_FETCH;
               end
            end else if (imem_busywait) begin
               if (!stall) begin
                  if_id_instr_d = NOP_INSTR;
                  if_id_valid_d = 1'b0;
               end else begin
                  if_id_valid_d = if_id_valid_q;
               end
            end else if (stall) begin
               hold_pc_d    = pc_s;
               hold_instr_d = imem_readdata;
               hold_valid_d = 1'b1;
               state_d      = S_STALL;
            end else begin
               if_id_pc_d    = pc_s;
               if_id_pc4_d   = pc4_s;
               if_id_instr_d = imem_readdata;
               if_id_valid_d = 1'b1;
               pc_inc_s      = 1'b1;
            end
         end
         S_STALL: begin
            if (redirect) begin
               if_id_instr_d = NOP_INSTR;
               if_id_valid_d = 1'b0;
               hold_valid_d  = 1'b0;
               pc_load_s     = 1'b1;
               state_d       = S_FETCH;
            end else if (!stall) begin
               if_id_pc_d    = hold_pc_q;
               if_id_pc4_d   = hold_pc_q + 32'd4;
               if_id_instr_d = hold_instr_q;
               if_id_valid_d = hold_valid_q;
               hold_valid_d  = 1'b0;
               pc_inc_s      = 1'b1;
               state_d       = S_FETCH;
            end else begin
               state_d = S_STALL;
            end
         end
         S_DISCARD: begin
            if (redirect) begin
               if_id_instr_d = NOP_INSTR;
               if_id_valid_d = 1'b0;
               hold_valid_d  = 1'b0;
               if (imem_busywait) begin
                  pending_target_d = word_align(redirect_target);
               end else begin
                  pc_load_s = 1'b1;
                  state_d   = S_FETCH;
               end
            end else if (!imem_busywait) begin
               pc_load_s   = 1'b1;   // in-flight word is dropped here
               pc_target_s = pending_target_q;
               state_d     = S_FETCH;
            end else begin
               state_d = S_DISCARD;
            end
         end
         default: begin
            state_d = S_RESET;
         end
      endcase
   end

   // Request strobe decoded from the registered state only.
   always_comb begin
      case (state_q)
         S_FETCH, S_DISCARD: imem_read_s = 1'b1;
         default:            imem_read_s = 1'b0;
      endcase
   end

   // State, IF/ID, hold buffer and pending redirect target registers.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q          <= S_RESET;
         if_id_pc_q       <= 32'd0;
         if_id_pc4_q      <= 32'd0;
         if_id_instr_q    <= NOP_INSTR;
         if_id_valid_q    <= 1'b0;
         hold_pc_q        <= 32'd0;
         hold_instr_q     <= NOP_INSTR;
         hold_valid_q     <= 1'b0;
         pending_target_q <= 32'd0;
      end else begin
         state_q          <= state_d;
         if_id_pc_q       <= if_id_pc_d;
         if_id_pc4_q      <= if_id_pc4_d;
         if_id_instr_q    <= if_id_instr_d;
         if_id_valid_q    <= if_id_valid_d;
         hold_pc_q        <= hold_pc_d;
         hold_instr_q     <= hold_instr_d;
         hold_valid_q     <= hold_valid_d;
         pending_target_q <= pending_target_d;
      end
   end

   assign imem_addr   = pc_s;
   assign imem_read   = imem_read_s;
   assign if_id_pc    = if_id_pc_q;
   assign if_id_pc4   = if_id_pc4_q;
   assign if_id_instr = if_id_instr_q;
   assign if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by random
// busywait/stall/redirect traffic. Expected program order is kept as a queue
// of PCs (restarted on every redirect/reset); a monitor pops it whenever a new
// valid instruction enters IF/ID.
module tb_instruction_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] imem_addr, imem_readdata, redirect_target;
   logic        imem_read, imem_busywait, stall, redirect;
   logic [31:0] if_id_pc, if_id_pc4, if_id_instr;
   logic        if_id_valid;

   int          n_cmp = 0;
   int          n_fail = 0;
   int          n_deliv = 0;
   logic [31:0] exp_q[$];

   instruction_fetch_unit dut (
      .CLK(CLK), .RESET(RESET),
      .imem_addr(imem_addr), .imem_read(imem_read),
      .imem_readdata(imem_readdata), .imem_busywait(imem_busywait),
      .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
      .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
      .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
   );

   always #5 CLK = ~CLK;

   // Instruction memory contents: three fixed words, hash elsewhere.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0050_0093;
         32'h0000_0004: return 32'h00A0_0113;
         32'h0000_0008: return 32'h0020_81B3;
         default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      endcase
   endfunction

   assign imem_readdata = mem_word(imem_addr);

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic model_restart(input logic [31:0] start);
      exp_q.delete();
      exp_q.push_back(start & 32'hFFFF_FFFC);
   endtask

   // Drive one cycle of inputs (from just after a falling edge) and return
   // just after the next falling edge.
   task automatic step(input logic bw, input logic st, input logic rd, input logic [31:0] tgt);
      imem_busywait   = bw;
      stall           = st;
      redirect        = rd;
      redirect_target = tgt;
      if (rd) model_restart(tgt);
      while (exp_q.size() < 4) exp_q.push_back(exp_q[$] + 32'd4);
      @(negedge CLK);
      #1;
   endtask

   // Monitor: protocol checks and scoreboard pops at each falling edge.
   initial begin : monitor
      logic [31:0] prev_addr;
      logic        prev_read;
      logic [31:0] e_pc;
      prev_addr = 32'd0;
      prev_read = 1'b0;
      forever begin
         @(negedge CLK);
         if (RESET) begin
            if (prev_read && imem_busywait) begin
               check32("req_held_read", {31'd0, imem_read}, 32'd1);
               check32("req_held_addr", imem_addr, prev_addr);
            end
            check32("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
            if (redirect) begin
               check32("flush_valid", {31'd0, if_id_valid}, 32'd0);
               check32("flush_instr", if_id_instr, NOP);
            end else if (!stall && if_id_valid) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL sb_empty: got pc %08h expected no instruction", if_id_pc);
               end else begin
                  e_pc = exp_q.pop_front();
                  n_deliv++;
                  check32("ifid_pc", if_id_pc, e_pc);
                  check32("ifid_pc4", if_id_pc4, e_pc + 32'd4);
                  check32("ifid_instr", if_id_instr, mem_word(e_pc));
               end
            end else if (!if_id_valid) begin
               check32("bubble_instr", if_id_instr, NOP);
            end
            prev_read = imem_read;
            prev_addr = imem_addr;
         end else begin
            prev_read = 1'b0;
         end
      end
   end

   // Hard stop if the run never reaches its summary.
   initial begin
      #1000000;
      $display("FAIL watchdog: got no end of test expected finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int deliv_start;
      RESET = 1'b0; imem_busywait = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = 32'd0;
      model_restart(32'd0);
      repeat (2) @(negedge CLK);
      check32("rst_read", {31'd0, imem_read}, 32'd0);
      check32("rst_valid", {31'd0, if_id_valid}, 32'd0);
      check32("rst_instr", if_id_instr, NOP);
      check32("rst_pc", if_id_pc, 32'd0);
      check32("rst_pc4", if_id_pc4, 32'd0);
      check32("rst_addr", imem_addr, 32'd0);
      #1 RESET = 1'b1;
      check32("post_rst_idle", {31'd0, imem_read}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'd0);
      check32("first_read", {31'd0, imem_read}, 32'd1);
      check32("first_addr", imem_addr, 32'd0);
      repeat (4) step(1'b0, 1'b0, 1'b0, 32'd0);          // delivers 0,4,8,C

      // busywait held three cycles on 0x10
      repeat (3) begin
         step(1'b1, 1'b0, 1'b0, 32'd0);
         check32("bw_addr", imem_addr, 32'h10);
         check32("bw_read", {31'd0, imem_read}, 32'd1);
         check32("bw_valid", {31'd0, if_id_valid}, 32'd0);
         check32("bw_instr", if_id_instr, NOP);
      end
      step(1'b0, 1'b0, 1'b0, 32'd0);                     // delivers 0x10
      repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0);          // 0x14..0x1C

      // hit at 0x20 under a two-cycle stall
      repeat (2) begin
         step(1'b0, 1'b1, 1'b0, 32'd0);
         check32("stall_read", {31'd0, imem_read}, 32'd0);
         check32("stall_hold_pc", if_id_pc, 32'h1C);
         check32("stall_hold_instr", if_id_instr, mem_word(32'h1C));
      end
      step(1'b0, 1'b0, 1'b0, 32'd0);
      check32("unstall_pc", if_id_pc, 32'h20);
      check32("unstall_addr", imem_addr, 32'h24);

      // redirect beats stall, target low bits masked
      step(1'b0, 1'b1, 1'b1, 32'h103);
      check32("redir_addr", imem_addr, 32'h100);

      // redirect during busywait, then retarget before the word arrives
      step(1'b1, 1'b0, 1'b1, 32'h200);
      check32("disc_addr0", imem_addr, 32'h100);
      check32("disc_read", {31'd0, imem_read}, 32'd1);
      step(1'b1, 1'b0, 1'b1, 32'h300);
      check32("disc_addr1", imem_addr, 32'h100);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      check32("disc_addr2", imem_addr, 32'h100);
      step(1'b0, 1'b0, 1'b0, 32'd0);
      check32("disc_done_addr", imem_addr, 32'h300);
      check32("disc_dropped", {31'd0, if_id_valid}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'd0);
      check32("after_disc_pc", if_id_pc, 32'h300);

      // PC wrap at the top of the address space
      step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 1'b0, 32'd0);
      check32("wrap_pc4", if_id_pc4, 32'd0);
      check32("wrap_addr", imem_addr, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'd0);                     // delivers 0, pc=4

      // reset in the middle of a busywait
      step(1'b1, 1'b0, 1'b0, 32'd0);
      RESET = 1'b0;
      #1;
      check32("midrst_read", {31'd0, imem_read}, 32'd0);
      check32("midrst_addr", imem_addr, 32'd0);
      check32("midrst_valid", {31'd0, if_id_valid}, 32'd0);
      model_restart(32'd0);
      imem_busywait = 1'b0;
      @(negedge CLK);
      #1 RESET = 1'b1;
      step(1'b0, 1'b0, 1'b0, 32'd0);
      check32("restart_addr", imem_addr, 32'd0);

      // random traffic
      deliv_start = n_deliv;
      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(99) < 30), ($urandom_range(99) < 20),
              ($urandom_range(99) < 8), $urandom);
      end
      repeat (5) step(1'b0, 1'b0, 1'b0, 32'd0);
      n_cmp++;
      if (n_deliv - deliv_start < 200) begin
         n_fail++;
         $display("FAIL liveness: got %0d deliveries expected at least 200", n_deliv - deliv_start);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
IF stage of the 5-stage RV32IM pipeline. Owns the PC, issues requests to instruction memory and handles its busywait. Produces the IF/ID pipeline register (pc, pc+4, instruction, valid) that feeds the decode stage and control unit. Honours stall from the hazard unit and redirects (taken branch/jal/jalr) resolved in EX.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) inserted on flush/empty

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-low reset
imem_addr  out  32  word-aligned fetch address, bits [1:0] always 0
imem_read  out  1  fetch request; address stable while high
imem_readdata  in  32  instruction word; valid when imem_read=1 and imem_busywait=0
imem_busywait  in  1  memory not ready; request must be held
stall  in  1  hazard unit: hold IF/ID and PC
redirect  in  1  EX stage: control transfer taken, flush younger instructions
redirect_target  in  32  new PC; bits [1:0] ignored (forced 0)
if_id_pc  out  32  PC of instruction in IF/ID
if_id_pc4  out  32  if_id_pc + 4 (for jal/jalr link)
if_id_instr  out  32  instruction to decode
if_id_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (RESET=0, async): state=S_RESET, pc=RESET_PC, if_id_pc=0, if_id_pc4=0, if_id_instr=NOP_INSTR, if_id_valid=0, imem_read=0, buffer empty.
- States: S_RESET, S_FETCH, S_STALL, S_DISCARD. Encoding is 2-bit.
- S_RESET: imem_read=0 for one cycle after reset release, then -> S_FETCH.
- S_FETCH: imem_read=1, imem_addr=pc.
  - hit (busywait=0), stall=0, redirect=0: IF/ID <= {pc, pc+4, imem_readdata, 1}; pc <= pc+4; stay. Throughput 1 instr/cycle.
  - hit, stall=1: IF/ID unchanged; word saved to hold buffer with its pc; -> S_STALL; pc unchanged.
  - busywait=1, stall=0: IF/ID <= bubble (NOP_INSTR, valid=0, pc fields unchanged).
  - busywait=1, stall=1: IF/ID unchanged.
- S_STALL: imem_read=0. When stall=0: IF/ID <= buffer contents, valid=1; pc <= pc+4; -> S_FETCH.
- S_DISCARD: imem_read=1 with the old address (request in flight cannot be withdrawn). When busywait=0: data dropped, pc <= pending_target, -> S_FETCH.
- Redirect priority: reset > redirect > stall > normal.
  - redirect=1 in any non-reset state: IF/ID <= NOP_INSTR, valid=0 (flush overrides stall); hold buffer cleared.
  - In S_FETCH with busywait=1: pending_target <= target, -> S_DISCARD.
  - Otherwise: pc <= target, -> S_FETCH. A hit in the same cycle is discarded.
  - Redirect while in S_DISCARD overwrites pending_target.
- PC arithmetic is modulo 2^32: 32'hFFFFFFFC + 4 = 0. if_id_pc4 computed from the same pc, same wrap.
- Mid-operation reset: in-flight request is abandoned; imem_read drops asynchronously.
- No combinational path from stall/redirect to imem_addr; imem_read is registered-state-decoded only.

Decomposition:
- Shared package (riscv_pkg): NOP_INSTR constant, RESET_PC default, fetch state encoding constants.
- One sub-module: pc_reg (PC register with async active-low reset, load-enable, +4 incrementer, target load with [1:0] masked).

Test Plan:
- Reset release, memory zero-wait, words at 0,4,8 = 0x00500093,0x00A00113,0x002081B3 -> IF/ID shows pc 0/4/8 on consecutive cycles, valid=1, pc4 = 4/8/12.
- busywait=1 for 3 cycles on addr 0x10 -> imem_addr held 0x10, imem_read=1, IF/ID NOP valid=0 for 3 cycles, then instr at 0x10 valid=1.
- Hit at 0x20 with stall=1 for 2 cycles -> IF/ID unchanged, imem_read=0; after stall drops IF/ID = word@0x20, next fetch addr 0x24.
- redirect=1, target 0x103 while stall=1 -> next cycle if_id_valid=0, instr=0x00000013, imem_addr=0x100.
- redirect to 0x200 during busywait, then second redirect to 0x300 before busywait drops -> old address held until ready, returned word dropped, next fetch 0x300.
- PC=0xFFFFFFFC hit -> if_id_pc4=0, next imem_addr=0. Assert RESET mid-busywait -> imem_read=0 immediately, restart at RESET_PC.
